// File: rtl/hps_ext_pkg.sv
// Shared definitions for the HPS EXT_BUS register block: command offsets,
// EXT_BUS bit positions and the word-counter width helper.
package hps_ext_pkg;

    typedef enum logic [1:0] {
        OFS_GET_STATUS = 2'd0,
        OFS_SET_REGS   = 2'd1,
        OFS_SET_PULSE  = 2'd2,
        OFS_GET_PULSE  = 2'd3
    } cmd_ofs_t;

    localparam int EXT_W        = 36;
    localparam int EXT_DOUT_LSB = 0;
    localparam int EXT_DIN_LSB  = 16;
    localparam int EXT_DOUT_EN  = 32;
    localparam int EXT_STROBE   = 33;
    localparam int EXT_ENABLE   = 34;

    // Word 0 plus the longest decoded run plus the saturation slot.
    function automatic int byte_cnt_width(input int n_status, input int n_ctrl, input int extra);
        int m;
        m = (n_status > n_ctrl) ? n_status : n_ctrl;
        return $clog2(m + 3 + extra);
    endfunction

endpackage

// File: rtl/hps_ext_regs_if.sv
// EXT_BUS signal group. Valid/ready here is strobe-only: io_strobe with
// io_enable high presents one word; the response appears on io_dout after that edge.
interface hps_ext_regs_if;
    import hps_ext_pkg::*;

    logic [15:0] io_dout;
    logic [15:0] io_din;
    logic        dout_en;
    logic        io_strobe;
    logic        io_enable;
    logic [EXT_W-1:0] bus;

    // Flat 36-bit view in the legacy EXT_BUS layout.
    always_comb begin
        bus = '0;
        bus[EXT_DOUT_LSB +: 16] = io_dout;
        bus[EXT_DIN_LSB +: 16]  = io_din;
        bus[EXT_DOUT_EN]        = dout_en;
        bus[EXT_STROBE]         = io_strobe;
        bus[EXT_ENABLE]         = io_enable;
    end

    modport slave  (output io_dout, output dout_en, input io_din, input io_strobe, input io_enable);
    modport master (input io_dout, input dout_en, input bus, output io_din, output io_strobe, output io_enable);

endinterface

// File: rtl/hps_ext_pulse_bank.sv
// Sticky request lines: set by the bus, cleared per line by the core.
// A set and an acknowledge on the same bit in the same cycle leaves it set.
module hps_ext_pulse_bank #(
    parameter int N_PULSE = 4
) (
    input  logic               clk_sys,
    input  logic               reset,
    input  logic               set_en,
    input  logic [N_PULSE-1:0] set_mask,
    input  logic [N_PULSE-1:0] ack,
    output logic [N_PULSE-1:0] pend
);

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            pend <= '0;
        end else begin
            pend <= (pend & ~ack) | (set_en ? set_mask : '0);
        end
    end

endmodule

// File: rtl/hps_ext_regs.sv
// HPS EXT_BUS decoder: status snapshot, auto-increment control registers, sticky pulses.
// Define HPS_EXT_REGS_CHKSUM_EN to append an XOR checksum word to GET_STATUS.
module hps_ext_regs
    import hps_ext_pkg::*;
#(
    parameter int CMD_BASE = 'hf0,
    parameter int N_STATUS = 22,
    parameter int N_CTRL   = 4,
    parameter int N_PULSE  = 4
) (
    input  logic                  clk_sys,
    input  logic                  reset,
    hps_ext_regs_if.slave         EXT_BUS,
    input  logic                  hps_rise,
    input  logic [16*N_STATUS-1:0] status_in,
    output logic [16*N_CTRL-1:0]  ctrl_out,
    output logic [N_CTRL-1:0]     ctrl_wr,
    output logic [N_PULSE-1:0]    pulse_out,
    input  logic [N_PULSE-1:0]    pulse_ack
);

`ifdef HPS_EXT_REGS_CHKSUM_EN
    localparam int CHK_WORDS = 1;
`else
    localparam int CHK_WORDS = 0;
`endif
    localparam int CW = byte_cnt_width(N_STATUS, N_CTRL, CHK_WORDS);
    localparam int IW = $clog2(N_CTRL + 1);
    localparam logic [15:0] BASE = 16'(CMD_BASE);

    function automatic logic is_owned(input logic [15:0] c);
        return (c >= BASE) && ((c - BASE) < 16'd4);
    endfunction

    function automatic cmd_ofs_t ofs_of(input logic [15:0] c);
        return cmd_ofs_t'(2'(c - BASE));
    endfunction

    logic [CW-1:0] byte_cnt;
    logic [15:0]   cmd;
    logic [15:0]   io_dout_q;
    logic          dout_en_q;
    logic [7:0]    evt_cnt;
    logic          rise_q;
    logic [IW-1:0] idx;
    logic [15:0]   snap [N_STATUS];
    logic [15:0]   ctrl [N_CTRL];
    logic [15:0]   status_word;
    logic          strobe, din_owned, cmd_owned, word0_get_status, pulse_set_en;

    assign EXT_BUS.io_dout = io_dout_q;
    assign EXT_BUS.dout_en = dout_en_q;

    assign strobe           = EXT_BUS.io_enable && EXT_BUS.io_strobe;
    assign din_owned        = is_owned(EXT_BUS.io_din);
    assign cmd_owned        = is_owned(cmd);
    assign word0_get_status = strobe && (byte_cnt == '0) && din_owned
                              && (ofs_of(EXT_BUS.io_din) == OFS_GET_STATUS);
    assign pulse_set_en     = strobe && (byte_cnt == CW'(1)) && cmd_owned
                              && (ofs_of(cmd) == OFS_SET_PULSE);

`ifdef HPS_EXT_REGS_CHKSUM_EN
    logic [15:0] chk_now, chk_q;

    always_comb begin
        chk_now = {8'd0, evt_cnt};
        for (int k = 0; k < N_STATUS; k++) chk_now = chk_now ^ status_in[16*k +: 16];
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) chk_q <= '0;
        else if (word0_get_status) chk_q <= chk_now;
    end
`endif

    always_comb begin
        status_word = '0;
        for (int k = 0; k < N_STATUS; k++) begin
            if (byte_cnt == CW'(k + 1)) status_word = snap[k];
        end
`ifdef HPS_EXT_REGS_CHKSUM_EN
        if (byte_cnt == CW'(N_STATUS + 1)) status_word = chk_q;
`endif
    end

    always_comb begin
        ctrl_out = '0;
        for (int i = 0; i < N_CTRL; i++) ctrl_out[16*i +: 16] = ctrl[i];
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            byte_cnt  <= '0;
            cmd       <= '0;
            io_dout_q <= '0;
            dout_en_q <= 1'b0;
            evt_cnt   <= '0;
            rise_q    <= 1'b0;
            idx       <= '0;
            ctrl_wr   <= '0;
            for (int k = 0; k < N_STATUS; k++) snap[k] <= '0;
            for (int i = 0; i < N_CTRL; i++) ctrl[i] <= '0;
        end else begin
            ctrl_wr <= '0;
            rise_q  <= hps_rise;
            if (hps_rise != rise_q) evt_cnt <= evt_cnt + 8'd1;

            if (!EXT_BUS.io_enable) begin
                byte_cnt  <= '0;
                cmd       <= '0;
                io_dout_q <= '0;
                dout_en_q <= 1'b0;
            end else if (EXT_BUS.io_strobe) begin
                io_dout_q <= '0;
                if (byte_cnt != '1) byte_cnt <= byte_cnt + 1'b1;

                if (byte_cnt == '0) begin
                    cmd       <= EXT_BUS.io_din;
                    dout_en_q <= din_owned;
                    if (din_owned) io_dout_q <= {8'd0, evt_cnt};
                    if (word0_get_status) begin
                        for (int k = 0; k < N_STATUS; k++) snap[k] <= status_in[16*k +: 16];
                    end
                end else if (cmd_owned) begin
                    case (ofs_of(cmd))
                        OFS_GET_STATUS: io_dout_q <= status_word;
                        OFS_SET_REGS: begin
                            // Index is clamped to N_CTRL on load so it can only saturate there.
                            if (byte_cnt == CW'(1)) begin
                                idx <= (EXT_BUS.io_din >= 16'(N_CTRL)) ? IW'(N_CTRL) : IW'(EXT_BUS.io_din);
                            end else if (idx != IW'(N_CTRL)) begin
                                for (int i = 0; i < N_CTRL; i++) begin
                                    if (idx == IW'(i)) begin
                                        ctrl[i]    <= EXT_BUS.io_din;
                                        ctrl_wr[i] <= 1'b1;
                                    end
                                end
                                idx <= idx + 1'b1;
                            end
                        end
                        OFS_GET_PULSE: if (byte_cnt == CW'(1)) io_dout_q <= 16'(pulse_out);
                        default: ;
                    endcase
                end
            end
        end
    end

    hps_ext_pulse_bank #(.N_PULSE(N_PULSE)) u_pulse_bank (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .set_en   (pulse_set_en),
        .set_mask (EXT_BUS.io_din[N_PULSE-1:0]),
        .ack      (pulse_ack),
        .pend     (pulse_out)
    );

endmodule

// File: tb/tb_hps_ext_regs.sv
// Directed bench for hps_ext_regs: status snapshot, event counter wrap,
// auto-increment register writes, sticky pulses, foreign commands and mid-transaction reset.
module tb_hps_ext_regs;
    import hps_ext_pkg::*;

    localparam int N_STATUS = 22;
    localparam int N_CTRL   = 4;
    localparam int N_PULSE  = 4;
    localparam logic [15:0] CMD_BASE = 16'hf0;

    logic clk_sys = 1'b0;
    logic reset   = 1'b1;
    logic hps_rise = 1'b0;
    logic [16*N_STATUS-1:0] status_in;
    logic [16*N_CTRL-1:0]   ctrl_out;
    logic [N_CTRL-1:0]      ctrl_wr;
    logic [N_PULSE-1:0]     pulse_out;
    logic [N_PULSE-1:0]     pulse_ack = '0;

    hps_ext_regs_if ext_if ();

    hps_ext_regs #(
        .CMD_BASE ('hf0),
        .N_STATUS (N_STATUS),
        .N_CTRL   (N_CTRL),
        .N_PULSE  (N_PULSE)
    ) dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .EXT_BUS   (ext_if),
        .hps_rise  (hps_rise),
        .status_in (status_in),
        .ctrl_out  (ctrl_out),
        .ctrl_wr   (ctrl_wr),
        .pulse_out (pulse_out),
        .pulse_ack (pulse_ack)
    );

    always #5 clk_sys = ~clk_sys;

    int n_tests = 0;
    int n_fail  = 0;
    logic [15:0] st_old [N_STATUS];
    logic [15:0] rsp;
    logic [15:0] exp_w;
    logic [15:0] chk_exp;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h expected 'h%0h", tag, got, exp);
        end
    endtask

    task automatic txn_open();
        @(negedge clk_sys);
        ext_if.io_enable = 1'b1;
    endtask

    task automatic txn_close();
        @(negedge clk_sys);
        ext_if.io_enable = 1'b0;
        ext_if.io_din    = '0;
    endtask

    // One strobed word; r is the response registered at that strobe's edge.
    task automatic bus_word(input logic [15:0] din, output logic [15:0] r);
        @(negedge clk_sys);
        ext_if.io_din    = din;
        ext_if.io_strobe = 1'b1;
        @(negedge clk_sys);
        ext_if.io_strobe = 1'b0;
        r = ext_if.io_dout;
    endtask

    initial begin
        ext_if.io_din    = '0;
        ext_if.io_strobe = 1'b0;
        ext_if.io_enable = 1'b0;
        for (int k = 0; k < N_STATUS; k++) begin
            st_old[k] = 16'h1000 + 16'(k) * 16'h0101;
        end
        st_old[3] = 16'h1234;
        for (int k = 0; k < N_STATUS; k++) status_in[16*k +: 16] = st_old[k];

        repeat (3) @(negedge clk_sys);
        reset = 1'b0;
        @(negedge clk_sys);
        check_eq("rst_io_dout",   64'(ext_if.io_dout), 64'h0);
        check_eq("rst_dout_en",   64'(ext_if.dout_en), 64'h0);
        check_eq("rst_ctrl_out",  64'(ctrl_out),       64'h0);
        check_eq("rst_ctrl_wr",   64'(ctrl_wr),        64'h0);
        check_eq("rst_pulse_out", 64'(pulse_out),      64'h0);

        // 258 toggles wrap the 8-bit event counter to 2.
        for (int i = 0; i < 258; i++) begin
            @(negedge clk_sys);
            hps_rise = ~hps_rise;
        end
        @(negedge clk_sys);

        // GET_STATUS with a mid-transaction change of status_in.
        txn_open();
        bus_word(CMD_BASE, rsp);
        check_eq("gs_w0_evt", 64'(rsp), 64'h0002);
        check_eq("gs_dout_en", 64'(ext_if.bus[EXT_DOUT_EN]), 64'h1);
        chk_exp = 16'h0002;
        for (int k = 0; k < N_STATUS; k++) chk_exp = chk_exp ^ st_old[k];
        for (int w = 1; w <= 34; w++) begin
            bus_word(16'h0000, rsp);
            if (w <= N_STATUS) exp_w = st_old[w-1];
`ifdef HPS_EXT_REGS_CHKSUM_EN
            else if (w == N_STATUS + 1) exp_w = chk_exp;
`endif
            else exp_w = 16'h0000;
            check_eq($sformatf("gs_word%0d", w), 64'(rsp), 64'(exp_w));
            if (w == 4) check_eq("gs_word4_1234", 64'(rsp), 64'h1234);
            if (w == 3) begin
                for (int k = 0; k < N_STATUS; k++) status_in[16*k +: 16] = ~st_old[k];
            end
        end
        txn_close();

        // SET_REGS idx=2, AAAA, 5555, FFFF (third data word dropped).
        txn_open();
        bus_word(CMD_BASE + 16'd1, rsp);
        check_eq("sr_w0_evt", 64'(rsp), 64'h0002);
        check_eq("sr_dout_en", 64'(ext_if.dout_en), 64'h1);
        bus_word(16'h0002, rsp);
        bus_word(16'hAAAA, rsp);
        check_eq("sr_wr2",    64'(ctrl_wr),  64'h4);
        check_eq("sr_ctrl2",  64'(ctrl_out), 64'h0000_AAAA_0000_0000);
        @(negedge clk_sys);
        check_eq("sr_wr2_off", 64'(ctrl_wr), 64'h0);
        bus_word(16'h5555, rsp);
        check_eq("sr_wr3",    64'(ctrl_wr),  64'h8);
        check_eq("sr_ctrl3",  64'(ctrl_out), 64'h5555_AAAA_0000_0000);
        @(negedge clk_sys);
        check_eq("sr_wr3_off", 64'(ctrl_wr), 64'h0);
        bus_word(16'hFFFF, rsp);
        check_eq("sr_drop_wr",   64'(ctrl_wr),  64'h0);
        check_eq("sr_drop_ctrl", 64'(ctrl_out), 64'h5555_AAAA_0000_0000);
        txn_close();

        // SET_PULSE 0005, then ack bit 0.
        txn_open();
        bus_word(CMD_BASE + 16'd2, rsp);
        bus_word(16'h0005, rsp);
        check_eq("sp_set", 64'(pulse_out), 64'h5);
        txn_close();
        @(negedge clk_sys);
        pulse_ack = 4'b0001;
        @(negedge clk_sys);
        pulse_ack = 4'b0000;
        check_eq("sp_ack0", 64'(pulse_out), 64'h4);

        // Simultaneous set and ack of bit 2: set wins.
        txn_open();
        bus_word(CMD_BASE + 16'd2, rsp);
        @(negedge clk_sys);
        ext_if.io_din    = 16'h0004;
        ext_if.io_strobe = 1'b1;
        pulse_ack        = 4'b0100;
        @(negedge clk_sys);
        ext_if.io_strobe = 1'b0;
        pulse_ack        = 4'b0000;
        check_eq("sp_set_wins", 64'(pulse_out), 64'h4);
        txn_close();

        // GET_PULSE.
        txn_open();
        bus_word(CMD_BASE + 16'd3, rsp);
        bus_word(16'h0000, rsp);
        check_eq("gp_pend", 64'(rsp), 64'h0004);
        txn_close();

        // Foreign commands: E0 and CMD_BASE+4.
        txn_open();
        bus_word(16'h00E0, rsp);
        check_eq("e0_w0",      64'(rsp),            64'h0);
        check_eq("e0_dout_en", 64'(ext_if.dout_en), 64'h0);
        bus_word(16'h000B, rsp);
        check_eq("e0_w1", 64'(rsp), 64'h0);
        bus_word(16'h1111, rsp);
        check_eq("e0_ctrl",  64'(ctrl_out),  64'h5555_AAAA_0000_0000);
        check_eq("e0_pulse", 64'(pulse_out), 64'h4);
        txn_close();
        txn_open();
        bus_word(CMD_BASE + 16'd4, rsp);
        check_eq("f4_w0",      64'(rsp),            64'h0);
        check_eq("f4_dout_en", 64'(ext_if.dout_en), 64'h0);
        bus_word(16'h000B, rsp);
        check_eq("f4_w1", 64'(rsp), 64'h0);
        bus_word(16'h2222, rsp);
        check_eq("f4_ctrl",  64'(ctrl_out),  64'h5555_AAAA_0000_0000);
        check_eq("f4_pulse", 64'(pulse_out), 64'h4);
        txn_close();

        // Reset during a SET_REGS data word.
        txn_open();
        bus_word(CMD_BASE + 16'd1, rsp);
        bus_word(16'h0000, rsp);
        @(negedge clk_sys);
        ext_if.io_din    = 16'hBEEF;
        ext_if.io_strobe = 1'b1;
        reset            = 1'b1;
        @(negedge clk_sys);
        ext_if.io_strobe = 1'b0;
        check_eq("mr_ctrl_out",  64'(ctrl_out),       64'h0);
        check_eq("mr_ctrl_wr",   64'(ctrl_wr),        64'h0);
        check_eq("mr_pulse_out", 64'(pulse_out),      64'h0);
        check_eq("mr_dout_en",   64'(ext_if.dout_en), 64'h0);
        check_eq("mr_io_dout",   64'(ext_if.io_dout), 64'h0);
        reset = 1'b0;
        txn_close();

        txn_open();
        bus_word(CMD_BASE + 16'd1, rsp);
        check_eq("post_w0_evt",  64'(rsp),            64'h0);
        check_eq("post_dout_en", 64'(ext_if.dout_en), 64'h1);
        bus_word(16'h0000, rsp);
        bus_word(16'h1357, rsp);
        check_eq("post_ctrl0", 64'(ctrl_out), 64'h0000_0000_0000_1357);
        check_eq("post_wr0",   64'(ctrl_wr),  64'h1);
        txn_close();

        repeat (2) @(negedge clk_sys);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hps_ext_regs.md
# hps_ext_regs

Parametrised successor to the HPS EXT_BUS command decoder. It replaces hard-wired status and command lists with three parts: a generic status snapshot bank, a 16-bit control register file with auto-increment writes, and a bank of sticky pulse requests with per-line acknowledge. It sits between the HPS EXT_BUS and core logic such as the blitter, audio and LZ4 paths.

## Interface
Parameters:
- CMD_BASE, 'hf0: first command code. The block owns codes CMD_BASE..CMD_BASE+3.
- N_STATUS, 22: number of 16-bit status words returned by GET_STATUS (1..30).
- N_CTRL, 4: number of 16-bit control registers (1..30).
- N_PULSE, 4: number of sticky pulse lines (1..16).

Ports:
- clk_sys  in  1  sole clock; all logic is on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- EXT_BUS  inout  36  [15:0] io_dout (driven), [31:16] io_din, [32] dout_en (driven), [33] io_strobe, [34] io_enable.
- hps_rise  in  1  level toggled by the core for each event; same clock domain, no synchroniser.
- status_in  in  16*N_STATUS  status words; word k is bits [16k+15:16k].
- ctrl_out  out  16*N_CTRL  control register contents.
- ctrl_wr  out  N_CTRL  one-cycle strobe, bit i asserted in the cycle after ctrl[i] is written.
- pulse_out  out  N_PULSE  sticky request lines.
- pulse_ack  in  N_PULSE  core clears the matching pulse_out bit.

## Operation
- Transaction framing:
  - While io_enable is low: byte_cnt=0, cmd=0, io_dout=0, dout_en=0.
  - The control registers, pulses and event counter are NOT cleared by io_enable low.
- On each io_strobe with io_enable high:
  - io_dout defaults to 0.
  - byte_cnt increments and saturates at all-ones.
- Word 0 (byte_cnt==0):
  - cmd<=io_din.
  - dout_en<=1 only if io_din is in CMD_BASE..CMD_BASE+3.
  - If dout_en is set, io_dout<={8'd0, evt_cnt}.
- Event counter evt_cnt (8 bit): increments on every hps_rise edge, either polarity, wrapping 255->0. It counts regardless of bus activity.
- GET_STATUS (offset 0):
  - At word 0 all of status_in is captured into snap.
  - Word k (1..N_STATUS) returns snap[k-1]; later words return 0.
  - All words of one transaction are therefore mutually consistent.
- SET_REGS (offset 1):
  - Word 1 loads idx.
  - Each later word writes ctrl[idx], pulses ctrl_wr[idx], then increments idx.
  - Writes with idx>=N_CTRL are dropped; idx saturates and does not wrap.
- SET_PULSE (offset 2): word 1 ORs io_din[N_PULSE-1:0] into pend. Bits above N_PULSE are ignored.
- GET_PULSE (offset 3): word 1 returns pend, zero-extended.
- pend clearing: pend[i] clears when pulse_ack[i]=1. If SET_PULSE and pulse_ack hit the same bit in the same cycle, the set wins.
- Commands outside the owned range: no state changes; dout_en=0.

## Timing
- io_dout and dout_en are registered. The response to strobe n is valid from the edge at strobe n and is sampled by the HPS at strobe n+1.
- ctrl_out updates on the edge of the data strobe. ctrl_wr is high for exactly that one following cycle.
- pulse_out equals pend directly (registered), with 1 cycle from strobe to output.
- pulse_ack takes effect on the next edge.
- Reset values: io_dout=0, dout_en=0, byte_cnt=0, cmd=0, evt_cnt=0, snap=0, idx=0, ctrl_out=0, ctrl_wr=0, pulse_out=0.
- Reset asserted mid-transaction aborts it. The HPS sees dout_en=0 and must restart.
- byte_cnt width is $clog2(max(N_STATUS,N_CTRL)+3). Saturation holds the last decoded word position: GET_STATUS keeps returning 0 and SET_REGS keeps dropping writes.

## Configuration
- HPS_EXT_REGS_CHKSUM_EN defined:
  - GET_STATUS word N_STATUS+1 returns the XOR of snap[0..N_STATUS-1] XOR {8'd0, evt_cnt at word 0}.
  - byte_cnt width grows by the extra word.
- HPS_EXT_REGS_CHKSUM_EN undefined: that word returns 0 and no XOR logic is built.

## Structure
- Shared package hps_ext_pkg holds:
  - command offsets (OFS_GET_STATUS=0, OFS_SET_REGS=1, OFS_SET_PULSE=2, OFS_GET_PULSE=3);
  - the byte_cnt width function;
  - the EXT_BUS bit-position constants.
- One sub-module, hps_ext_pulse_bank: the N_PULSE sticky set/ack register with set-priority.
- Snapshot, register file and decoder stay in the top module.

## Test plan
- Reset, then GET_STATUS with N_STATUS=22 and status word 3 = 'h1234:
  - word 4 read returns 'h1234;
  - word 23 returns 0, or the XOR value when HPS_EXT_REGS_CHKSUM_EN is defined;
  - changing status_in mid-transaction does not alter later words.
- Toggle hps_rise 258 times, then read word 0 of GET_STATUS: returns 2.
- SET_REGS with words idx=2, 'hAAAA, 'h5555, 'hFFFF at N_CTRL=4:
  - ctrl[2]='hAAAA and ctrl[3]='h5555;
  - ctrl_wr[2] then ctrl_wr[3] each high for one cycle;
  - the third data word is dropped.
- SET_PULSE 'h0005 with N_PULSE=4:
  - pulse_out='b0101 one cycle later;
  - pulse_ack[0] gives 'b0100;
  - a simultaneous SET_PULSE 'h0004 and pulse_ack[2] leaves bit 2 set.
- Command 'hE0 and command CMD_BASE+4: dout_en stays 0 and no register changes.
- Assert reset during a SET_REGS data word: all outputs return to their reset values; the next transaction after reset release works normally.
